// File: rtl/mem_op_sequencer_pkg.sv
// Shared opcode, ALU-select and state encodings for the memory-op control sequencer.
package mem_op_sequencer_pkg;

    localparam logic [4:0] OP_LDW  = 5'b00000;
    localparam logic [4:0] OP_LDWI = 5'b00001;
    localparam logic [4:0] OP_STW  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_e;

    // Instruction class captured at dispatch; selects the T5..T7 behaviour.
    typedef enum logic [1:0] {
        CLS_IMM = 2'd0,
        CLS_LD  = 2'd1,
        CLS_ST  = 2'd2
    } cls_e;

endpackage

// File: rtl/mem_op_sequencer_mem_wait_timer.sv
// Wait-state counter: zero on entry to a memory state, counts while held, flags the last cycle.
module mem_wait_timer #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] cnt_o,
    output logic       last_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == 4'(MEM_WAIT));

endmodule

// File: rtl/mem_op_sequencer.sv
// Moore control sequencer driving the datapath strobes for fetch, ldw, ldwi, stw, addi, nop, halt.
module mem_op_sequencer
    import mem_op_sequencer_pkg::*;
#(
    parameter int IR_W      = 32,
    parameter int OPCODE_W  = 5,
    parameter int MEM_WAIT  = 0,
    parameter int ALU_SEL_W = 5
) (
    input  logic                 Clock_i,
    input  logic                 Clear_i,
    input  logic [IR_W-1:0]      ir_i,
    output logic                 PCout_o,
    output logic                 IncPC_o,
    output logic                 PC_enable_o,
    output logic                 MAR_enable_o,
    output logic                 MDR_read_o,
    output logic                 MDR_enable_o,
    output logic                 MDRout_o,
    output logic                 IR_enable_o,
    output logic                 RAM_write_o,
    output logic                 Gra_o,
    output logic                 Grb_o,
    output logic                 BAout_o,
    output logic                 R_in_o,
    output logic                 R_out_o,
    output logic                 Cout_o,
    output logic                 Y_enable_o,
    output logic                 ZLowIn_o,
    output logic                 ZLowout_o,
    output logic [ALU_SEL_W-1:0] alu_op_o,
    output logic                 inst_done_o,
    output logic                 illegal_op_o,
    output logic                 halted_o,
    output logic [3:0]           state_o
);

    state_e     state_q, state_d;
    cls_e       cls_q, cls_d;
    logic [3:0] wcnt;
    logic       wlast, wait_st, hold;
    logic [4:0] opc;
    logic       unused_ir;

    assign opc       = 5'(ir_i[IR_W-1 -: OPCODE_W]);
    assign unused_ir = ^ir_i[IR_W-OPCODE_W-1:0];

    // Memory-access states that stretch to MEM_WAIT+1 cycles.
    assign wait_st = (state_q == S_T1)
                   || (state_q == S_T6 && cls_q == CLS_LD)
                   || (state_q == S_T7 && cls_q == CLS_ST);
    assign hold    = wait_st && !wlast;

    mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk_i  (Clock_i),
        .rst_ni (Clear_i),
        .clr_i  (!hold),
        .inc_i  (hold),
        .cnt_o  (wcnt),
        .last_o (wlast)
    );

    always_ff @(posedge Clock_i or negedge Clear_i) begin
        if (!Clear_i) begin
            state_q <= S_RST;
            cls_q   <= CLS_IMM;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        unique case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  if (wlast) state_d = S_T2;
            S_T2: begin
                case (opc)
                    OP_LDW:          begin state_d = S_T3; cls_d = CLS_LD;  end
                    OP_LDWI, OP_ADDI: begin state_d = S_T3; cls_d = CLS_IMM; end
                    OP_STW:          begin state_d = S_T3; cls_d = CLS_ST;  end
                    OP_HALT:         state_d = S_HALT;
                    default:         state_d = S_T0;
                endcase
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (cls_q == CLS_IMM) ? S_T0 : S_T6;
            S_T6:   if (cls_q == CLS_ST || wlast) state_d = S_T7;
            S_T7:   if (cls_q == CLS_LD || wlast) state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        PCout_o      = 1'b0;
        IncPC_o      = 1'b0;
        PC_enable_o  = 1'b0;
        MAR_enable_o = 1'b0;
        MDR_read_o   = 1'b0;
        MDR_enable_o = 1'b0;
        MDRout_o     = 1'b0;
        IR_enable_o  = 1'b0;
        RAM_write_o  = 1'b0;
        Gra_o        = 1'b0;
        Grb_o        = 1'b0;
        BAout_o      = 1'b0;
        R_in_o       = 1'b0;
        R_out_o      = 1'b0;
        Cout_o       = 1'b0;
        Y_enable_o   = 1'b0;
        ZLowIn_o     = 1'b0;
        ZLowout_o    = 1'b0;
        alu_op_o     = '0;
        inst_done_o  = 1'b0;
        illegal_op_o = 1'b0;
        halted_o     = 1'b0;
        unique case (state_q)
            S_T0: begin
                PCout_o      = 1'b1;
                MAR_enable_o = 1'b1;
                IncPC_o      = 1'b1;
                ZLowIn_o     = 1'b1;
            end
            S_T1: begin
                ZLowout_o    = 1'b1;
                MDR_read_o   = 1'b1;
                PC_enable_o  = (wcnt == 4'd0);
                MDR_enable_o = wlast;
            end
            S_T2: begin
                MDRout_o    = 1'b1;
                IR_enable_o = 1'b1;
                case (opc)
                    OP_NOP: inst_done_o = 1'b1;
                    OP_LDW, OP_LDWI, OP_STW, OP_ADDI, OP_HALT: ;
                    default: illegal_op_o = 1'b1;
                endcase
            end
            S_T3: begin
                Grb_o      = 1'b1;
                BAout_o    = 1'b1;
                Y_enable_o = 1'b1;
            end
            S_T4: begin
                Cout_o   = 1'b1;
                ZLowIn_o = 1'b1;
                alu_op_o = ALU_SEL_W'(ALU_ADD);
            end
            S_T5: begin
                ZLowout_o = 1'b1;
                if (cls_q == CLS_IMM) begin
                    Gra_o       = 1'b1;
                    R_in_o      = 1'b1;
                    inst_done_o = 1'b1;
                end else begin
                    MAR_enable_o = 1'b1;
                end
            end
            S_T6: begin
                if (cls_q == CLS_LD) begin
                    MDR_read_o   = 1'b1;
                    MDR_enable_o = wlast;
                end else begin
                    // MDR_read low steers the bus into the MDR for the store.
                    Gra_o        = 1'b1;
                    R_out_o      = 1'b1;
                    MDR_enable_o = 1'b1;
                end
            end
            S_T7: begin
                MDRout_o = 1'b1;
                if (cls_q == CLS_LD) begin
                    Gra_o       = 1'b1;
                    R_in_o      = 1'b1;
                    inst_done_o = 1'b1;
                end else begin
                    RAM_write_o = 1'b1;
                    inst_done_o = wlast;
                end
            end
            S_HALT: halted_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Scoreboarded bench: three sequencers with MEM_WAIT 0/1/2, per-cycle expected strobe vectors.
module tb_mem_op_sequencer;
    import mem_op_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [31:0] ir = '0;

    always #5 clk = ~clk;

    logic [2:0][17:0] strb;
    logic [2:0][4:0]  alu;
    logic [2:0][3:0]  st;
    logic [2:0]       done, ill, hlt;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_op_sequencer #(.MEM_WAIT(g)) dut (
            .Clock_i(clk), .Clear_i(clr_n), .ir_i(ir),
            .PCout_o(strb[g][17]), .IncPC_o(strb[g][16]), .PC_enable_o(strb[g][15]),
            .MAR_enable_o(strb[g][14]), .MDR_read_o(strb[g][13]), .MDR_enable_o(strb[g][12]),
            .MDRout_o(strb[g][11]), .IR_enable_o(strb[g][10]), .RAM_write_o(strb[g][9]),
            .Gra_o(strb[g][8]), .Grb_o(strb[g][7]), .BAout_o(strb[g][6]),
            .R_in_o(strb[g][5]), .R_out_o(strb[g][4]), .Cout_o(strb[g][3]),
            .Y_enable_o(strb[g][2]), .ZLowIn_o(strb[g][1]), .ZLowout_o(strb[g][0]),
            .alu_op_o(alu[g]), .inst_done_o(done[g]), .illegal_op_o(ill[g]),
            .halted_o(hlt[g]), .state_o(st[g])
        );
    end

    localparam logic [17:0] PCO  = 18'd1 << 17, INCPC = 18'd1 << 16, PCE  = 18'd1 << 15;
    localparam logic [17:0] MARE = 18'd1 << 14, MDRR  = 18'd1 << 13, MDRE = 18'd1 << 12;
    localparam logic [17:0] MDRO = 18'd1 << 11, IRE   = 18'd1 << 10, RAMW = 18'd1 << 9;
    localparam logic [17:0] GRA  = 18'd1 << 8,  GRB   = 18'd1 << 7,  BAO  = 18'd1 << 6;
    localparam logic [17:0] RIN  = 18'd1 << 5,  ROUT  = 18'd1 << 4,  COUT = 18'd1 << 3;
    localparam logic [17:0] YE   = 18'd1 << 2,  ZIN   = 18'd1 << 1,  ZOUT = 18'd1 << 0;
    localparam logic [17:0] BUSDRV = PCO | MDRO | ZOUT | BAO | COUT | ROUT;
    localparam logic [2:0]  NF = 3'b000, DN = 3'b100, IL = 3'b010, HL = 3'b001;
    localparam logic [4:0]  A0 = 5'b00000, AADD = 5'b00011;

    typedef struct {
        logic [29:0] v;
        int          idx;
    } exp_t;

    exp_t        q[$];
    int          tests = 0, fails = 0, nidx = 0;
    logic [1:0]  sel = 2'd0;
    string       tname = "";
    logic [29:0] got;
    exp_t        em;

    task automatic push(input logic [3:0] s, input logic [17:0] b, input logic [4:0] a,
                        input logic [2:0] f);
        exp_t e;
        e.v   = {s, b, a, f};
        e.idx = nidx;
        nidx  = nidx + 1;
        q.push_back(e);
    endtask

    // Fetch trace: T0, T1 stretched to mw+1 cycles, then T2 with the given dispatch flags.
    task automatic fetch(input int mw, input logic [2:0] f2);
        logic [17:0] b;
        push(S_T0, PCO | INCPC | MARE | ZIN, A0, NF);
        for (int k = 0; k <= mw; k++) begin
            b = ZOUT | MDRR;
            if (k == 0)  b = b | PCE;
            if (k == mw) b = b | MDRE;
            push(S_T1, b, A0, NF);
        end
        push(S_T2, MDRO | IRE, A0, f2);
    endtask

    task automatic exec34();
        push(S_T3, GRB | BAO | YE, A0, NF);
        push(S_T4, COUT | ZIN, AADD, NF);
    endtask

    task automatic start(input logic [1:0] s, input logic [31:0] v, input string n);
        clr_n = 1'b0;
        ir    = v;
        sel   = s;
        tname = n;
        nidx  = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: %0d expected cycles left, required 0", tname, q.size());
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            em  = q.pop_front();
            got = {st[sel], strb[sel], alu[sel], done[sel], ill[sel], hlt[sel]};
            tests++;
            if (got !== em.v) begin
                fails++;
                $display("FAIL %s[%0d] got=%h required=%h", tname, em.idx, got, em.v);
            end
        end
        for (int g = 0; g < 3; g++) begin
            if (!$onehot0(strb[g] & BUSDRV)) begin
                tests++;
                fails++;
                $display("FAIL busdrv_excl inst%0d got=%h required onehot0", g, strb[g] & BUSDRV);
            end
        end
    end

    initial begin
        start(2'd0, 32'hC800_0000, "nop_w0");
        push(S_RST, '0, A0, NF);
        fetch(0, DN);
        push(S_T0, PCO | INCPC | MARE | ZIN, A0, NF);
        clr_n = 1'b1;
        drain();

        start(2'd0, 32'h0880_0007, "ldwi_w0");
        push(S_RST, '0, A0, NF);
        fetch(0, NF);
        exec34();
        push(S_T5, ZOUT | GRA | RIN, A0, DN);
        push(S_T0, PCO | INCPC | MARE | ZIN, A0, NF);
        clr_n = 1'b1;
        drain();

        start(2'd2, 32'h1080_0000, "stw_w2");
        push(S_RST, '0, A0, NF);
        fetch(2, NF);
        exec34();
        push(S_T5, ZOUT | MARE, A0, NF);
        push(S_T6, GRA | ROUT | MDRE, A0, NF);
        push(S_T7, MDRO | RAMW, A0, NF);
        push(S_T7, MDRO | RAMW, A0, NF);
        push(S_T7, MDRO | RAMW, A0, DN);
        push(S_T0, PCO | INCPC | MARE | ZIN, A0, NF);
        clr_n = 1'b1;
        drain();

        start(2'd1, 32'h0080_0005, "ldw_w1");
        push(S_RST, '0, A0, NF);
        fetch(1, NF);
        exec34();
        push(S_T5, ZOUT | MARE, A0, NF);
        push(S_T6, MDRR, A0, NF);
        push(S_T6, MDRR | MDRE, A0, NF);
        push(S_T7, MDRO | GRA | RIN, A0, DN);
        push(S_T0, PCO | INCPC | MARE | ZIN, A0, NF);
        clr_n = 1'b1;
        drain();

        start(2'd0, 32'hF800_0000, "illegal_w0");
        push(S_RST, '0, A0, NF);
        fetch(0, IL);
        push(S_T0, PCO | INCPC | MARE | ZIN, A0, NF);
        push(S_T1, ZOUT | MDRR | PCE | MDRE, A0, NF);
        clr_n = 1'b1;
        drain();

        start(2'd0, 32'hD000_0000, "halt_w0");
        push(S_RST, '0, A0, NF);
        fetch(0, NF);
        for (int k = 0; k < 22; k++) push(S_HALT, '0, A0, HL);
        clr_n = 1'b1;
        drain();

        start(2'd2, 32'h1080_0000, "stw_abort");
        push(S_RST, '0, A0, NF);
        fetch(2, NF);
        exec34();
        push(S_T5, ZOUT | MARE, A0, NF);
        push(S_T6, GRA | ROUT | MDRE, A0, NF);
        push(S_T7, MDRO | RAMW, A0, NF);
        clr_n = 1'b1;
        drain();
        // Mid-T7: reset must kill the write before the next clock edge.
        clr_n = 1'b0;
        #1;
        tests++;
        if (strb[2][9] !== 1'b0) begin
            fails++;
            $display("FAIL abort_ramw got=%b required=0", strb[2][9]);
        end
        tests++;
        if ({st[2], strb[2], alu[2], done[2], ill[2], hlt[2]} !== {S_RST, 18'd0, A0, NF}) begin
            fails++;
            $display("FAIL abort_all got=%h required=%h",
                     {st[2], strb[2], alu[2], done[2], ill[2], hlt[2]}, {S_RST, 18'd0, A0, NF});
        end
        @(posedge clk);
        #1;
        tname = "stw_restart";
        nidx  = 0;
        push(S_RST, '0, A0, NF);
        push(S_T0, PCO | INCPC | MARE | ZIN, A0, NF);
        push(S_T1, ZOUT | MDRR | PCE, A0, NF);
        clr_n = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
